// File: rtl/button_debouncer.sv
// Per-button front end: two-flop synchroniser, cycle-count debounce FSM and a
// sticky press flag so that short presses survive until the consumer samples them.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_WIDTH       = 18,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic button_in,
  input  logic sample_ack,
  output logic button_out,
  output logic press_pulse,
  output logic level
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 raw_s;
  logic                 s1_r;
  logic                 s2_r;
  state_t               state_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic                 sticky_r;
  logic                 press_done_s;
  logic                 release_done_s;
  logic                 level_next_s;
  logic                 sticky_next_s;

  assign raw_s = button_in ^ ACTIVE_LOW;

  // Two-flop synchroniser for the asynchronous pin
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= raw_s;
      s2_r <= s1_r;
    end
  end

  // Next level and sticky value, shared by the FSM and the combined output
  always_comb begin
    press_done_s   = 1'b0;
    release_done_s = 1'b0;
    if ((state_r == PRESS_WAIT) && s2_r && (cnt_r == CNT_LAST)) begin
      press_done_s = 1'b1;
    end else begin
      press_done_s = 1'b0;
    end
    if ((state_r == RELEASE_WAIT) && !s2_r && (cnt_r == CNT_LAST)) begin
      release_done_s = 1'b1;
    end else begin
      release_done_s = 1'b0;
    end

    if (press_done_s) begin
      level_next_s = 1'b1;
    end else if (release_done_s) begin
      level_next_s = 1'b0;
    end else begin
      level_next_s = level;
    end

    // An accepted press outranks a simultaneous ack
    if (press_done_s) begin
      sticky_next_s = 1'b1;
    end else if (sample_ack) begin
      sticky_next_s = 1'b0;
    end else begin
      sticky_next_s = sticky_r;
    end
  end

  // Debounce FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= RELEASED;
      cnt_r       <= {CNT_WIDTH{1'b0}};
      level       <= 1'b0;
      sticky_r    <= 1'b0;
      press_pulse <= 1'b0;
      button_out  <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      level       <= level_next_s;
      sticky_r    <= sticky_next_s;
      button_out  <= level_next_s | sticky_next_s;
      case (state_r)
        RELEASED: begin
          if (s2_r) begin
            state_r <= PRESS_WAIT;
            cnt_r   <= {CNT_WIDTH{1'b0}};
          end else begin
            state_r <= RELEASED;
          end
        end
        PRESS_WAIT: begin
          if (!s2_r) begin
            state_r <= RELEASED;
          end else if (cnt_r == CNT_LAST) begin
            state_r     <= PRESSED;
            press_pulse <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        PRESSED: begin
          if (!s2_r) begin
            state_r <= RELEASE_WAIT;
            cnt_r   <= {CNT_WIDTH{1'b0}};
          end else begin
            state_r <= PRESSED;
          end
        end
        RELEASE_WAIT: begin
          if (s2_r) begin
            state_r <= PRESSED;
          end else if (cnt_r == CNT_LAST) begin
            state_r <= RELEASED;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        default: begin
          state_r <= RELEASED;
          cnt_r   <= {CNT_WIDTH{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, CNT_WIDTH=3,
// covering both pin polarities.
module tb_button_debouncer;

  logic clk;
  logic reset;
  logic button_in;
  logic low_in;
  logic sample_ack;
  logic button_out, press_pulse, level;
  logic low_button_out, low_press_pulse, low_level;

  int check_count;
  int pass_count;

  button_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(3), .ACTIVE_LOW(1'b0)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .button_in  (button_in),
    .sample_ack (sample_ack),
    .button_out (button_out),
    .press_pulse(press_pulse),
    .level      (level)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(3), .ACTIVE_LOW(1'b1)) u_dut_low (
    .clk        (clk),
    .reset      (reset),
    .button_in  (low_in),
    .sample_ack (sample_ack),
    .button_out (low_button_out),
    .press_pulse(low_press_pulse),
    .level      (low_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    check_count++;
    if (got === exp) begin
      pass_count++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  initial begin
    clk         = 1'b0;
    reset       = 1'b1;
    button_in   = 1'b0;
    low_in      = 1'b1;
    sample_ack  = 1'b0;
    check_count = 0;
    pass_count  = 0;

    step(2);
    check("reset_outs", {5'd0, level, button_out, press_pulse}, 8'd0);
    check("reset_low_outs", {5'd0, low_level, low_button_out, low_press_pulse}, 8'd0);
    reset = 1'b0;
    step(3);
    check("idle_outs", {5'd0, level, button_out, press_pulse}, 8'd0);

    // 1: clean press, release, and sticky held until ack
    button_in = 1'b1;
    step(1);
    step(5);
    check("t1_press_edge5", {6'd0, button_out, press_pulse}, 8'd0);
    step(1);
    check("t1_press_accept", {5'd0, level, button_out, press_pulse}, 8'd7);
    step(1);
    check("t1_pulse_one_cycle", {5'd0, level, button_out, press_pulse}, 8'd6);
    step(5);
    check("t1_held", {5'd0, level, button_out, press_pulse}, 8'd6);
    button_in = 1'b0;
    step(1);
    step(5);
    check("t1_release_edge5", {7'd0, level}, 8'd1);
    step(1);
    check("t1_release_level", {7'd0, level}, 8'd0);
    check("t1_release_sticky", {7'd0, button_out}, 8'd1);
    step(3);
    check("t1_sticky_hold", {7'd0, button_out}, 8'd1);
    sample_ack = 1'b1;
    step(1);
    sample_ack = 1'b0;
    check("t1_ack_clear", {5'd0, level, button_out, press_pulse}, 8'd0);

    // 2: bounce pattern 1,1,0,1,1,1,0 is rejected
    step(2);
    for (int i = 0; i < 14; i++) begin
      case (i)
        0, 1, 3, 4, 5: button_in = 1'b1;
        default:       button_in = 1'b0;
      endcase
      step(1);
      check("t2_bounce", {5'd0, level, button_out, press_pulse}, 8'd0);
    end

    // 3: six-cycle press is latched without an ack
    button_in = 1'b1;
    step(6);
    button_in = 1'b0;
    step(1);
    check("t3_accept", {5'd0, level, button_out, press_pulse}, 8'd7);
    step(5);
    check("t3_release_edge5", {7'd0, level}, 8'd1);
    step(1);
    check("t3_released", {6'd0, level, button_out}, 8'd1);
    for (int i = 0; i < 10; i++) begin
      step(10);
      check("t3_latched", {6'd0, level, button_out}, 8'd1);
    end
    sample_ack = 1'b1;
    step(1);
    sample_ack = 1'b0;
    check("t3_ack_clear", {7'd0, button_out}, 8'd0);

    // 4: ack on the acceptance edge loses to the set
    step(2);
    button_in = 1'b1;
    step(1);
    step(5);
    sample_ack = 1'b1;
    step(1);
    sample_ack = 1'b0;
    check("t4_accept_with_ack", {5'd0, level, button_out, press_pulse}, 8'd7);
    button_in = 1'b0;
    step(1);
    step(6);
    check("t4_sticky_survived", {6'd0, level, button_out}, 8'd1);
    sample_ack = 1'b1;
    step(1);
    sample_ack = 1'b0;
    check("t4_later_ack", {7'd0, button_out}, 8'd0);

    // 5: reset in PRESS_WAIT with cnt=2 forces a fresh debounce
    step(2);
    button_in = 1'b1;
    step(1);
    step(4);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("t5_reset_outs", {5'd0, level, button_out, press_pulse}, 8'd0);
    step(6);
    check("t5_not_yet", {5'd0, level, button_out, press_pulse}, 8'd0);
    step(1);
    check("t5_accept", {5'd0, level, button_out, press_pulse}, 8'd7);
    button_in = 1'b0;
    step(8);
    sample_ack = 1'b1;
    step(1);
    sample_ack = 1'b0;
    check("t5_cleared", {5'd0, level, button_out, press_pulse}, 8'd0);

    // 6: active-low pin
    check("t6_idle", {5'd0, low_level, low_button_out, low_press_pulse}, 8'd0);
    low_in = 1'b0;
    step(1);
    step(5);
    check("t6_press_edge5", {7'd0, low_button_out}, 8'd0);
    step(1);
    check("t6_accept", {5'd0, low_level, low_button_out, low_press_pulse}, 8'd7);
    low_in = 1'b1;
    step(1);
    step(5);
    check("t6_release_edge5", {7'd0, low_level}, 8'd1);
    step(1);
    check("t6_released", {6'd0, low_level, low_button_out}, 8'd1);
    sample_ack = 1'b1;
    step(1);
    sample_ack = 1'b0;
    check("t6_ack_clear", {7'd0, low_button_out}, 8'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
